seq_shifter: RTL and testbench
==============================

# seq_shifter

Parametrised multi-cycle shifter that performs logical, arithmetic and rotate shifts on a WIDTH-bit operand, at most STEP bit positions per clock. Operands enter on a valid/ready handshake and results leave on a second valid/ready handshake. Compared with the single-cycle 32-bit SLL/SRL unit, it adds arithmetic-right and rotate modes, back-pressure, and a selectable area/latency trade-off. It sits behind the ALU issue stage as the shift functional unit.

## Interface

**Parameters**
- WIDTH, 32: operand width; power of two, ≥ 4.
- STEP, 4: maximum shift applied per cycle; power of two, 1..WIDTH/2.
- Derived SHW = $clog2(WIDTH): shift-amount width.

**Ports**
- clk, in, 1: single clock; all state updates on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: operand request.
- in_ready, out, 1: high only in IDLE.
- a, in, WIDTH: operand.
- shamt, in, SHW: shift amount, 0..WIDTH-1.
- op, in, 3: operation; 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; other codes are illegal.
- out_valid, out, 1: result available.
- out_ready, in, 1: consumer accepts result.
- result, out, WIDTH: shifted value, registered.
- err, out, 1: registered with result; set when op was illegal.
- busy, out, 1: high in BUSY or DONE.

## Operation

- States are IDLE, BUSY and DONE.
- **IDLE.** When in_valid && in_ready, latch acc=a, rem=shamt and op.
  - If the op is illegal: acc=a, err=1, go to DONE.
  - Else if shamt==0: go to DONE.
  - Else: go to BUSY.
- **BUSY.** Each cycle:
  - s = min(rem, STEP).
  - acc = step(acc, s, op).
  - rem = rem − s.
  - Go to DONE when the new rem==0.
  - Inputs are ignored.
- **DONE.** out_valid=1; result and err are stable. When out_valid && out_ready, go to IDLE.
- **Per-op semantics** (acc is WIDTH bits; nothing is ever sign-extended beyond WIDTH):
  - SLL: zero fill at the LSB.
  - SRL: zero fill at the MSB.
  - SRA: replicate acc[WIDTH-1]. The sign is preserved stepwise, so the result equals $signed(a)>>>shamt.
  - ROL/ROR: bits wrap modulo WIDTH.
- **Defined behaviour for all values:**
  - shamt=0 returns a unchanged for every legal op.
  - shamt=WIDTH-1 is the largest legal shift.
- **Simultaneous events.** In DONE, in_valid is ignored; in_ready is 0. A new request can be accepted on the cycle after the output handshake.

## Timing

- **Reset.** Asynchronous assertion forces the following immediately, including in the middle of BUSY or DONE:
  - state=IDLE
  - result=0, err=0, out_valid=0, busy=0
  - in_ready=1
  - rem and acc cleared
  
  The in-flight operation is discarded. Release is synchronous to clk.
- **Latency.** Let L = 1 + ceil(shamt/STEP) rising edges from the accept edge until out_valid is seen high. Illegal op or shamt=0 gives L=1. Worst case is 1 + (WIDTH-1+STEP-1)/STEP; the default configuration gives 9.
- **Throughput.** One operation per L+1 cycles minimum, with out_ready held high.
- **Back-pressure.** out_valid stays high and result/err stay stable until out_ready is sampled high. No timeout.
- **Combinational paths.** in_ready is a function of state only. There are no combinational paths from in_* to out_*.

## Structure

- **Package shifter_pkg:**
  - op-code localparams: OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR.
  - State encoding: IDLE, BUSY, DONE.
  - Function or localparam for legal-op check.
- **Sub-module shift_step** (combinational, parametrised WIDTH/STEP):
  - Inputs: acc, s (0..STEP), op. Output: next acc.
  - Built as a log2(STEP)+1 stage mini barrel.
- **Top seq_shifter:** FSM, acc/rem/op registers, handshakes.

## Test plan

Default parameters (WIDTH=32, STEP=4) unless stated.

1. **SLL:** a=12345678, shamt=1 → result 2468ACF0, err=0, out_valid 2 edges after accept. Also a=80000001, shamt=1 → 00000002.
2. **SRA:** a=80000000, shamt=31 → FFFFFFFF, latency 9. **SRL** with the same inputs → 00000001.
3. **Rotate:** ROR a=12345678, shamt=8 → 78123456, latency 3. ROL a=80000001, shamt=4 → 00000018.
4. **Zero shift with back-pressure:** SRL a=12345678, shamt=0 → 12345678 at latency 1. Hold out_ready=0 for 5 cycles: result stays stable, in_ready=0, busy=1. in_valid pulses during the stall are not accepted.
5. **Illegal op:** op=111, a=DEADBEEF, shamt=5 → result DEADBEEF, err=1, latency 1. The next legal op clears err.
6. **Reset mid-operation:** SRL a=FFFFFFFF, shamt=16, assert rst_n low two cycles after accept → out_valid=0 and result=0 immediately. After release: in_ready=1, then SLL a=00000001, shamt=31 → 80000000. Re-run scenarios 1–3 with STEP=1 (latency 1+shamt) and STEP=16 (latency ≤3).

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the multi-cycle shifter: op codes, FSM states and
// the legal-op check.
package shifter_pkg;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_ROR;
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One iteration of the shifter: a log2(STEP)+1 stage barrel that moves acc by
// s (0..STEP) positions in the direction and fill mode selected by op.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [SW-1:0]    s,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] next_acc
);

  logic [WIDTH-1:0] stage [SW+1];

  assign stage[0] = acc;

  for (genvar gi = 0; gi < SW; gi++) begin : g_stage
    localparam int K = 1 << gi;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] shd;

    assign cur = stage[gi];

    always_comb begin
      shd = cur;
      case (op)
        OP_SLL:  shd = cur << K;
        OP_SRL:  shd = cur >> K;
        OP_SRA:  shd = $signed(cur) >>> K;
        OP_ROL:  shd = (cur << K) | (cur >> (WIDTH - K));
        OP_ROR:  shd = (cur >> K) | (cur << (WIDTH - K));
        default: shd = cur;
      endcase
    end

    assign stage[gi+1] = s[gi] ? shd : cur;
  end

  assign next_acc = stage[SW];

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: accepts an operand, shifts it at most STEP bits per
// clock, then holds the result until the consumer takes it.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);

  localparam int SW = $clog2(STEP) + 1;
  localparam logic [SHW-1:0] STEP_V = SHW'(STEP);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [SHW-1:0]   rem_reg, rem_next;
  logic [2:0]       op_reg, op_next;
  logic             err_reg, err_next;

  logic [SHW-1:0]   s_full;
  logic [WIDTH-1:0] step_acc;

  assign s_full = (rem_reg > STEP_V) ? STEP_V : rem_reg;

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .acc     (acc_reg),
    .s       (s_full[SW-1:0]),
    .op      (op_reg),
    .next_acc(step_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      rem_reg   <= '0;
      op_reg    <= OP_SLL;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      rem_reg   <= rem_next;
      op_reg    <= op_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    rem_next   = rem_reg;
    op_next    = op_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          acc_next = a;
          rem_next = shamt;
          op_next  = op;
          err_next = !op_legal(op);
          // Illegal ops pass the operand through untouched, flagged by err.
          if (!op_legal(op) || shamt == '0) begin
            rem_next   = '0;
            state_next = DONE;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        acc_next = step_acc;
        rem_next = rem_reg - s_full;
        if (rem_reg == s_full) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = acc_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: three instances (STEP=4, 1, 16) share the
// request inputs so every vector also checks the latency of each variant.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [4:0]  shamt = '0;
  logic [2:0]  op = '0;

  logic        ir4, ov4, err4, busy4;
  logic        ir1, ov1, err1, busy1;
  logic        ir16, ov16, err16, busy16;
  logic [31:0] res4, res1, res16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .a(a),
    .shamt(shamt), .op(op), .out_valid(ov4), .out_ready(out_ready),
    .result(res4), .err(err4), .busy(busy4)
  );

  seq_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a),
    .shamt(shamt), .op(op), .out_valid(ov1), .out_ready(out_ready),
    .result(res1), .err(err1), .busy(busy1)
  );

  seq_shifter #(.WIDTH(32), .STEP(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .a(a),
    .shamt(shamt), .op(op), .out_valid(ov16), .out_ready(out_ready),
    .result(res16), .err(err16), .busy(busy16)
  );

  // Issue one request to all three instances and collect result, err and
  // latency (edges from the accept edge, inclusive). -1 means timed out.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [4:0] sh,
                        output logic [31:0] r4, output logic [31:0] r1, output logic [31:0] r16,
                        output logic e4, output logic e1, output logic e16,
                        output int l4, output int l1, output int l16);
    l4 = -1; l1 = -1; l16 = -1;
    r4 = 'x; r1 = 'x; r16 = 'x;
    e4 = 1'bx; e1 = 1'bx; e16 = 1'bx;
    @(negedge clk);
    op = o; a = av; shamt = sh; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (l4 < 0 && ov4)   begin l4 = n;  r4 = res4;   e4 = err4;   end
      if (l1 < 0 && ov1)   begin l1 = n;  r1 = res1;   e1 = err1;   end
      if (l16 < 0 && ov16) begin l16 = n; r16 = res16; e16 = err16; end
      if (l4 > 0 && l1 > 0 && l16 > 0) break;
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0 || busy4 !== 1'b0 || res4 !== 32'h0 || err4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ir=%b ov=%b busy=%b res=%h err=%b required 1 0 0 00000000 0",
               ir4, ov4, busy4, res4, err4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic check_vec(input string name, input logic [2:0] o, input logic [31:0] av,
                           input logic [4:0] sh, input logic [31:0] exp_r, input logic exp_e,
                           input int x4, input int x1, input int x16);
    logic [31:0] r4, r1, r16;
    logic e4, e1, e16;
    int l4, l1, l16;
    run_op(o, av, sh, r4, r1, r16, e4, e1, e16, l4, l1, l16);
    $display("%s: op=%0d a=%h sh=%0d -> %h/%h/%h err=%b%b%b lat=%0d/%0d/%0d",
             name, o, av, sh, r4, r1, r16, e4, e1, e16, l4, l1, l16);
    total++;
    if (r4 !== exp_r || r1 !== exp_r || r16 !== exp_r) begin
      bad++;
      $display("FAIL %s_result: got %h/%h/%h required %h", name, r4, r1, r16, exp_r);
    end
    total++;
    if (e4 !== exp_e || e1 !== exp_e || e16 !== exp_e) begin
      bad++;
      $display("FAIL %s_err: got %b%b%b required %b", name, e4, e1, e16, exp_e);
    end
    total++;
    if (l4 != x4 || l1 != x1 || l16 != x16) begin
      bad++;
      $display("FAIL %s_latency: got %0d/%0d/%0d required %0d/%0d/%0d",
               name, l4, l1, l16, x4, x1, x16);
    end
  endtask

  task automatic test_sll();
    check_vec("sll_1", 3'b000, 32'h12345678, 5'd1, 32'h2468ACF0, 1'b0, 2, 2, 2);
    check_vec("sll_msb", 3'b000, 32'h80000001, 5'd1, 32'h00000002, 1'b0, 2, 2, 2);
  endtask

  task automatic test_right();
    check_vec("sra_31", 3'b010, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 9, 32, 3);
    check_vec("srl_31", 3'b001, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 9, 32, 3);
    check_vec("sra_pos", 3'b010, 32'h40000000, 5'd5, 32'h02000000, 1'b0, 3, 6, 2);
  endtask

  task automatic test_rotate();
    check_vec("ror_8", 3'b100, 32'h12345678, 5'd8, 32'h78123456, 1'b0, 3, 9, 2);
    check_vec("rol_4", 3'b011, 32'h80000001, 5'd4, 32'h00000018, 1'b0, 2, 5, 2);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    op = 3'b001; a = 32'h12345678; shamt = 5'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (ov4 !== 1'b1 || res4 !== 32'h12345678) begin
      bad++;
      $display("FAIL zero_shift: ov=%b res=%h required 1 12345678", ov4, res4);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      a = 32'hA5A5A5A5;
      shamt = 5'd3;
      @(posedge clk); #1;
      total++;
      if (ov4 !== 1'b1 || res4 !== 32'h12345678 || ir4 !== 1'b0 || busy4 !== 1'b1 || err4 !== 1'b0) begin
        bad++;
        $display("FAIL stall_%0d: ov=%b res=%h ir=%b busy=%b err=%b required 1 12345678 0 1 0",
                 i, ov4, res4, ir4, busy4, err4);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1 || busy4 !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: ov=%b ir=%b busy=%b required 0 1 0", ov4, ir4, busy4);
    end
    $display("backpressure: held 5 cycles, result %h", res4);
  endtask

  task automatic test_illegal();
    check_vec("illegal", 3'b111, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF, 1'b1, 1, 1, 1);
    check_vec("after_illegal", 3'b000, 32'h00000001, 5'd1, 32'h00000002, 1'b0, 2, 2, 2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op = 3'b001; a = 32'hFFFFFFFF; shamt = 5'd16; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    total++;
    if (busy4 !== 1'b1 || ov4 !== 1'b0) begin
      bad++;
      $display("FAIL mid_busy: busy=%b ov=%b required 1 0", busy4, ov4);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ov4 !== 1'b0 || res4 !== 32'h0 || busy4 !== 1'b0 || ir4 !== 1'b1 ||
        ov16 !== 1'b0 || res16 !== 32'h0 || res1 !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: ov=%b res=%h busy=%b ir=%b ov16=%b res16=%h res1=%h required 0 0 0 1 0 0 0",
               ov4, res4, busy4, ir4, ov16, res16, res1);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (ir4 !== 1'b1 || ir1 !== 1'b1 || ir16 !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_ready: ir=%b%b%b required 111", ir4, ir1, ir16);
    end
    $display("reset mid-operation applied");
    check_vec("sll_31", 3'b000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 9, 32, 3);
  endtask

  task automatic test_back_to_back();
    check_vec("b2b_rol", 3'b011, 32'h0000000F, 5'd30, 32'hC0000003, 1'b0, 9, 31, 3);
    check_vec("b2b_ror", 3'b100, 32'h00000001, 5'd1, 32'h80000000, 1'b0, 2, 2, 2);
  endtask

  initial begin
    test_reset();
    test_sll();
    test_right();
    test_rotate();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
